usbf_scan_ctrl: RTL and testbench

- Single-clock test-access controller that drives the serial scan wrapper around one usbf_top instance.
- Takes a parallel stimulus vector and shifts it serially into the wrapper's input chain.
- Lets the core run for a programmable number of cycles, then pulses the parallel-load strobe and shifts the captured core response back into a parallel result register.
- Sits directly upstream of the wrapper (drives its data-in, shift enable and load) and consumes its serial data-out.

---
 rtl/usbf_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_usbf_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbf_scan_ctrl.sv
// Scan-wrapper test-access controller for one usbf_top: serial shift-in, core run, capture, shift-out.
// Optional compare logic (exp_i/mask_i/mismatch_o/err_cnt_o) is enabled by defining USBF_SCAN_CMP_EN.
module usbf_scan_ctrl #(
    parameter int IN_W   = 125,
    parameter int OUT_W  = 121,
    parameter int CNT_W  = 8,
    parameter int WAIT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WAIT_W-1:0] run_cycles_i,
    input  logic [IN_W-1:0]   stim_i,
    output logic              sdo_o,
    output logic              scan_en_o,
    output logic              load_o,
    input  logic              sdi_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [OUT_W-1:0]  resp_o
`ifdef USBF_SCAN_CMP_EN
    ,
    input  logic [OUT_W-1:0]  exp_i,
    input  logic [OUT_W-1:0]  mask_i,
    output logic              mismatch_o,
    output logic [15:0]       err_cnt_o
`endif
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
    localparam logic [2:0] ST_WAIT      = 3'd2;
    localparam logic [2:0] ST_LOAD      = 3'd3;
    localparam logic [2:0] ST_SHIFT_OUT = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [IN_W-1:0]  stim_q;
    logic [OUT_W-2:0] resp_sh;
    logic [OUT_W-1:0] resp_next;
    logic             start_acc;
    logic             shift_last;

    // The final response bit is folded straight into resp_o, so the shifter is one bit short.
    assign resp_next  = {resp_sh, sdi_i};
    assign start_acc  = (state == ST_IDLE) && start_i;
    assign shift_last = (state == ST_SHIFT_OUT) && (cnt == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            run_cnt   <= '0;
            stim_q    <= '0;
            resp_sh   <= '0;
            resp_o    <= '0;
            sdo_o     <= 1'b0;
            scan_en_o <= 1'b0;
            load_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        stim_q    <= stim_i;
                        run_cnt   <= {{(CNT_W-WAIT_W){1'b0}}, run_cycles_i};
                        cnt       <= IN_LAST;
                        sdo_o     <= stim_i[IN_W-1];
                        scan_en_o <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= ST_SHIFT_IN;
                    end
                end
                ST_SHIFT_IN: begin
                    // MSB leaves first so that bit k ends up at wrapper index k.
                    if (cnt != '0) begin
                        cnt    <= cnt - CNT_ONE;
                        sdo_o  <= stim_q[IN_W-2];
                        stim_q <= {stim_q[IN_W-2:0], 1'b0};
                    end else begin
                        sdo_o <= 1'b0;
                        if (run_cnt != '0) begin
                            scan_en_o <= 1'b0;
                            state     <= ST_WAIT;
                        end else begin
                            load_o <= 1'b1;
                            state  <= ST_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (run_cnt == CNT_ONE) begin
                        run_cnt   <= '0;
                        scan_en_o <= 1'b1;
                        load_o    <= 1'b1;
                        state     <= ST_LOAD;
                    end else begin
                        run_cnt <= run_cnt - CNT_ONE;
                    end
                end
                ST_LOAD: begin
                    load_o <= 1'b0;
                    cnt    <= OUT_LAST;
                    state  <= ST_SHIFT_OUT;
                end
                ST_SHIFT_OUT: begin
                    if (cnt != '0) begin
                        cnt     <= cnt - CNT_ONE;
                        resp_sh <= resp_next[OUT_W-2:0];
                    end else begin
                        resp_o    <= resp_next;
                        scan_en_o <= 1'b0;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    sdo_o     <= 1'b0;
                    scan_en_o <= 1'b0;
                    load_o    <= 1'b0;
                    busy_o    <= 1'b0;
                    done_o    <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef USBF_SCAN_CMP_EN
    logic [OUT_W-1:0] exp_q;
    logic [OUT_W-1:0] mask_q;
    logic             cmp_fail;

    assign cmp_fail = |((resp_next ^ exp_q) & mask_q);

    // Verdict is taken on the same edge that publishes resp_o, so it lines up with done_o.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exp_q      <= '0;
            mask_q     <= '0;
            mismatch_o <= 1'b0;
            err_cnt_o  <= '0;
        end else if (start_acc) begin
            exp_q      <= exp_i;
            mask_q     <= mask_i;
            mismatch_o <= 1'b0;
        end else if (shift_last) begin
            mismatch_o <= cmp_fail;
            if (cmp_fail && (err_cnt_o != 16'hFFFF)) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_usbf_scan_ctrl.sv
// Directed bench for usbf_scan_ctrl with a behavioural scan-wrapper model around a stand-in core.
// Latency is counted in clock edges from the edge that accepts start_i to the edge that samples done_o.
module tb_usbf_scan_ctrl;

    localparam int IN_W   = 125;
    localparam int OUT_W  = 121;
    localparam int CNT_W  = 8;
    localparam int WAIT_W = 4;
    localparam int BUDGET = 400;

    localparam logic [OUT_W-1:0] PATTERN = {1'b1, {30{4'h5}}};
    localparam logic [IN_W-1:0]  STIM_A  = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-1:0]  STIM_B  = {5{25'h0F0F0F1}};
    localparam logic [IN_W-1:0]  STIM_C  = {5{25'h1234567}};

    logic              clk_i        = 1'b0;
    logic              rst_i        = 1'b0;
    logic              start_i      = 1'b0;
    logic [WAIT_W-1:0] run_cycles_i = '0;
    logic [IN_W-1:0]   stim_i       = '0;
    logic              sdo_o;
    logic              scan_en_o;
    logic              load_o;
    logic              sdi_i;
    logic              busy_o;
    logic              done_o;
    logic [OUT_W-1:0]  resp_o;
`ifdef USBF_SCAN_CMP_EN
    logic [OUT_W-1:0]  exp_i  = '0;
    logic [OUT_W-1:0]  mask_i = '0;
    logic              mismatch_o;
    logic [15:0]       err_cnt_o;
`endif

    usbf_scan_ctrl #(
        .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .WAIT_W(WAIT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .run_cycles_i (run_cycles_i),
        .stim_i       (stim_i),
        .sdo_o        (sdo_o),
        .scan_en_o    (scan_en_o),
        .load_o       (load_o),
        .sdi_i        (sdi_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .resp_o       (resp_o)
`ifdef USBF_SCAN_CMP_EN
        ,
        .exp_i        (exp_i),
        .mask_i       (mask_i),
        .mismatch_o   (mismatch_o),
        .err_cnt_o    (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Wrapper model: load captures core outputs, otherwise scan_en shifts both chains.
    logic [IN_W-1:0]  in_chain      = '0;
    logic [OUT_W-1:0] out_chain     = '0;
    logic [IN_W-1:0]  captured_stim = '0;
    logic [OUT_W-1:0] core_out;
    logic             core_mode     = 1'b0;

    always_comb core_out = core_mode ? PATTERN : in_chain[IN_W-1:IN_W-OUT_W];
    assign sdi_i = out_chain[OUT_W-1];

    always @(posedge clk_i) begin
        if (load_o) begin
            out_chain     <= core_out;
            captured_stim <= in_chain;
        end else if (scan_en_o) begin
            in_chain  <= {in_chain[IN_W-2:0], sdo_o};
            out_chain <= {out_chain[OUT_W-2:0], 1'b0};
        end
    end

    int errors = 0;
    int checks = 0;
    int lat, sdo_cnt, sdo_first, load_cnt, load_at, pre_zero, zero_run, busy_gap;
    logic [IN_W-1:0]  stim_var;
    logic [OUT_W-1:0] exp_resp;

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_vec(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [IN_W-1:0] stim, input logic [WAIT_W-1:0] r);
        @(negedge clk_i);
        stim_i       = stim;
        run_cycles_i = r;
        start_i      = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // Observes one transaction cycle by cycle until done_o or the cycle budget runs out.
    task automatic watch_txn(input int pulse_at, input bit hold);
        lat = 0; sdo_cnt = 0; sdo_first = 0; load_cnt = 0; load_at = 0;
        pre_zero = -1; zero_run = 0; busy_gap = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk_i);
            if (i == pulse_at) start_i = 1'b1;
            if (!hold && i == pulse_at + 1) start_i = 1'b0;
            if (sdo_o) begin
                sdo_cnt++;
                if (sdo_first == 0) sdo_first = i;
            end
            if (!scan_en_o) begin
                zero_run++;
            end else begin
                if (load_o) pre_zero = zero_run;
                zero_run = 0;
            end
            if (load_o) begin
                load_cnt++;
                load_at = i;
            end
            if (!busy_o && !done_o) busy_gap++;
            if (done_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_done_pulse(input string tag);
        check_int({tag, "_busy_at_done"}, int'(busy_o), 0);
        @(negedge clk_i);
        check_int({tag, "_done_width"}, int'(done_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        check_int("rst_sdo", int'(sdo_o), 0);
        check_int("rst_scan_en", int'(scan_en_o), 0);
        check_int("rst_load", int'(load_o), 0);
        check_int("rst_busy", int'(busy_o), 0);
        check_int("rst_done", int'(done_o), 0);
        check_vec("rst_resp", 128'(resp_o), 128'(0));
        rst_i = 1'b1;
        @(negedge clk_i);

        // Walking one through the loop-back core, R=2
        core_mode = 1'b0;
        apply_stimulus(STIM_A, 4'd2);
        watch_txn(0, 1'b0);
        check_int("A_latency", lat, 250);
        check_int("A_sdo_count", sdo_cnt, 1);
        check_int("A_sdo_first", sdo_first, 1);
        check_int("A_load_count", load_cnt, 1);
        check_int("A_load_at", load_at, 128);
        check_int("A_pre_load_idle", pre_zero, 2);
        check_int("A_busy_gap", busy_gap, 0);
        check_vec("A_chain", 128'(captured_stim), 128'(STIM_A));
        check_vec("A_resp", 128'(resp_o), 128'(1) << 120);
        check_done_pulse("A");

        // Constant core response, R=2
        core_mode = 1'b1;
        apply_stimulus(STIM_B, 4'd2);
        watch_txn(0, 1'b0);
        check_int("B_latency", lat, 250);
        check_int("B_load_count", load_cnt, 1);
        check_int("B_pre_load_idle", pre_zero, 2);
        check_vec("B_chain", 128'(captured_stim), 128'(STIM_B));
        check_vec("B_resp", 128'(resp_o), 128'(PATTERN));
        check_done_pulse("B");

        // R=0: load follows the last shift-in cycle directly
        core_mode = 1'b0;
        stim_var  = STIM_C;
        exp_resp  = stim_var[IN_W-1:IN_W-OUT_W];
        apply_stimulus(STIM_C, 4'd0);
        watch_txn(0, 1'b0);
        check_int("C_latency", lat, 248);
        check_int("C_load_at", load_at, 126);
        check_int("C_pre_load_idle", pre_zero, 0);
        check_vec("C_resp", 128'(resp_o), 128'(exp_resp));
        check_done_pulse("C");

        // start_i re-pulsed at cycle 10 and held through DONE
        core_mode = 1'b1;
        apply_stimulus(STIM_B, 4'd2);
        watch_txn(10, 1'b1);
        check_int("D_latency", lat, 250);
        check_int("D_busy_gap", busy_gap, 0);
        check_vec("D_resp", 128'(resp_o), 128'(PATTERN));
        core_mode = 1'b0;
        stim_i    = STIM_C;
        @(negedge clk_i);
        check_int("D_idle_busy", int'(busy_o), 0);
        check_int("D_idle_scan_en", int'(scan_en_o), 0);
        check_int("D_idle_done", int'(done_o), 0);
        @(posedge clk_i);
        #1 start_i = 1'b0;
        watch_txn(0, 1'b0);
        check_int("D2_latency", lat, 250);
        check_vec("D2_resp", 128'(resp_o), 128'(exp_resp));
        check_done_pulse("D2");

        // Reset at cycle 60 of a transaction
        core_mode = 1'b1;
        apply_stimulus(STIM_B, 4'd2);
        repeat (60) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_int("E_rst_sdo", int'(sdo_o), 0);
        check_int("E_rst_scan_en", int'(scan_en_o), 0);
        check_int("E_rst_load", int'(load_o), 0);
        check_int("E_rst_busy", int'(busy_o), 0);
        check_int("E_rst_done", int'(done_o), 0);
        check_vec("E_rst_resp", 128'(resp_o), 128'(0));
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (200) begin
            @(negedge clk_i);
            if (done_o) break;
        end
        check_int("E_no_done", int'(done_o), 0);
        core_mode = 1'b0;
        apply_stimulus(STIM_A, 4'd2);
        watch_txn(0, 1'b0);
        check_int("E_latency", lat, 250);
        check_vec("E_resp", 128'(resp_o), 128'(1) << 120);

`ifdef USBF_SCAN_CMP_EN
        // Compare: match, single-bit miss, masked miss
        core_mode = 1'b1;
        exp_i  = PATTERN;
        mask_i = '1;
        apply_stimulus(STIM_B, 4'd2);
        watch_txn(0, 1'b0);
        check_int("F_match_mismatch", int'(mismatch_o), 0);
        check_int("F_match_errcnt", int'(err_cnt_o), 0);
        exp_i = PATTERN ^ (OUT_W'(1) << 7);
        apply_stimulus(STIM_B, 4'd2);
        watch_txn(0, 1'b0);
        check_int("F_miss_mismatch", int'(mismatch_o), 1);
        check_int("F_miss_errcnt", int'(err_cnt_o), 1);
        mask_i = ~(OUT_W'(1) << 7);
        apply_stimulus(STIM_B, 4'd2);
        watch_txn(0, 1'b0);
        check_int("F_masked_mismatch", int'(mismatch_o), 0);
        check_int("F_masked_errcnt", int'(err_cnt_o), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
